axi4s_downsize_trailing: RTL and testbench

Single-clock AXI4-Stream downsizer. It splits each wide input word into RATIO narrow output beats, least-significant bytes first. Packet length is carried as a trailing-bytes count in tuser on both sides, with 0 meaning a full word. It is the narrowing companion to the trailing-bytes upsizing path: it sits after wide packet processing and before a narrow transport or serializer. Empty narrow beats past the end of a packet are never emitted.

---
 rtl/axi4s_downsize_trailing.sv | 130 +++++++++++++
 tb/tb_axi4s_downsize_trailing.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4s_downsize_trailing.sv
// axi4s_downsize_trailing
//   AXI4-Stream width downsizer. Each accepted wide word is emitted as up to
//   RATIO narrow beats, least-significant slice first. Packet length rides in
//   tuser as a trailing-bytes count (0 = full word) on both sides, and slices
//   entirely past the end of a packet are never emitted.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   s_tdata/s_tuser     wide input word and trailing-byte count (last beat only)
//   s_tlast/s_tvalid    input end-of-packet and valid
//   s_tready            input ready (only combinational path from m_tready)
//   m_tdata/m_tuser     narrow output slice and its trailing-byte count
//   m_tlast/m_tvalid    output end-of-packet and valid (all outputs registered)
//   m_tready            output ready
module axi4s_downsize_trailing #(
   parameter int IN_BYTES = 8,
   parameter int RATIO    = 4,
   localparam int OUT_BYTES = IN_BYTES / RATIO,
   localparam int IUW       = $clog2(IN_BYTES),
   localparam int OUW       = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [8*IN_BYTES-1:0]  s_tdata,
   input  logic [IUW-1:0]         s_tuser,
   input  logic                   s_tlast,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   output logic [8*OUT_BYTES-1:0] m_tdata,
   output logic [OUW-1:0]         m_tuser,
   output logic                   m_tlast,
   output logic                   m_tvalid,
   input  logic                   m_tready
);

   localparam int OW   = 8 * OUT_BYTES;
   localparam int IDXW = $clog2(RATIO);
   localparam int OSH  = $clog2(OUT_BYTES);

   localparam logic [IUW:0]    FULL_B   = (IUW+1)'(IN_BYTES);
   localparam logic [IUW:0]    MOD_MASK = (IUW+1)'(OUT_BYTES - 1);
   localparam logic [IUW:0]    ONE_B    = (IUW+1)'(1);
   localparam logic [IDXW-1:0] ONE_I    = IDXW'(1);

   typedef enum logic {HOLD_EMPTY, SPLITTING} state_t;

   state_t                  state;
   logic [RATIO-1:0][OW-1:0] word;
   logic                    held_last;
   logic [OUW-1:0]          held_mod;
   logic [IDXW-1:0]         n_last;
   logic [IDXW-1:0]         idx;
   logic [IDXW-1:0]         nxt_idx;

   logic [IUW:0]            ld_b;
   logic [IDXW-1:0]         ld_n_last;
   logic [OUW-1:0]          ld_mod;
   logic                    final_beat;
   logic                    load;
   logic                    advance;

   // Valid-byte count B of the incoming word, its last beat index
   // (ceil(B/OUT_BYTES)-1) and the trailing count of its final slice.
   always_comb begin
      ld_b = FULL_B;
      if (s_tlast && (s_tuser != '0)) begin
         ld_b = {1'b0, s_tuser};
      end
      ld_n_last = IDXW'((ld_b - ONE_B) >> OSH);
      ld_mod    = OUW'(ld_b & MOD_MASK);
   end

   assign final_beat = (idx == n_last);
   assign nxt_idx    = idx + ONE_I;

   // Accepting on the final-beat handoff keeps the output gap-free.
   assign s_tready = !rst && ((state == HOLD_EMPTY) || (m_tready && final_beat));
   assign load     = s_tvalid && s_tready;
   assign advance  = (state == SPLITTING) && m_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HOLD_EMPTY;
         word      <= '0;
         held_last <= 1'b0;
         held_mod  <= '0;
         n_last    <= '0;
         idx       <= '0;
         m_tdata   <= '0;
         m_tuser   <= '0;
         m_tlast   <= 1'b0;
         m_tvalid  <= 1'b0;
      end else if (load) begin
         state     <= SPLITTING;
         word      <= s_tdata;
         held_last <= s_tlast;
         held_mod  <= ld_mod;
         n_last    <= ld_n_last;
         idx       <= '0;
         m_tvalid  <= 1'b1;
         m_tdata   <= s_tdata[OW-1:0];
         if (s_tlast && (ld_n_last == '0)) begin
            m_tlast <= 1'b1;
            m_tuser <= ld_mod;
         end else begin
            m_tlast <= 1'b0;
            m_tuser <= '0;
         end
      end else if (advance) begin
         if (final_beat) begin
            state    <= HOLD_EMPTY;
            idx      <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= '0;
         end else begin
            idx     <= nxt_idx;
            m_tdata <= word[nxt_idx];
            if (held_last && (nxt_idx == n_last)) begin
               m_tlast <= 1'b1;
               m_tuser <= held_mod;
            end else begin
               m_tlast <= 1'b0;
               m_tuser <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi4s_downsize_trailing.sv
// Testbench for axi4s_downsize_trailing (IN_BYTES=8, RATIO=4, OUT_BYTES=2).
// Inputs change on the falling edge; outputs are read 1 time unit later.
module tb_axi4s_downsize_trailing;

   localparam int IN_BYTES = 8;
   localparam int RATIO    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s_tdata;
   logic [2:0]  s_tuser;
   logic        s_tlast;
   logic        s_tvalid;
   logic        s_tready;
   logic [15:0] m_tdata;
   logic [0:0]  m_tuser;
   logic        m_tlast;
   logic        m_tvalid;
   logic        m_tready;

   always #5 clk = ~clk;

   axi4s_downsize_trailing #(.IN_BYTES(IN_BYTES), .RATIO(RATIO)) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tlast(s_tlast),
      .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic tv, input logic [63:0] d, input logic tl,
                       input logic [2:0] tu, input logic mr);
      @(negedge clk);
      s_tvalid = tv;
      s_tdata  = d;
      s_tlast  = tl;
      s_tuser  = tu;
      m_tready = mr;
      #1;
   endtask

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [2:0]  user;
      int          nbeats;
      logic [63:0] exp;
      logic [63:0] mask;
      logic        exp_last;
      logic        exp_user;
   } vec_t;

   vec_t vecs[7];

   // One word in, expected beats out with m_tready held high.
   task automatic apply_vec(input vec_t v, input string tag);
      int k = 0;
      logic [15:0] bm, be;
      step(1'b1, v.data, v.last, v.user, 1'b1);
      chk({tag, "_sready"}, s_tready, 1);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      chk({tag, "_latency"}, m_tvalid, 1);
      for (int c = 0; c < 12 && k < v.nbeats; c++) begin
         if (m_tvalid) begin
            bm = v.mask[k*16 +: 16];
            be = v.exp[k*16 +: 16];
            chk({tag, "_data"}, m_tdata & bm, be & bm);
            chk({tag, "_tlast"}, m_tlast, (k == v.nbeats - 1) ? v.exp_last : 1'b0);
            chk({tag, "_tuser"}, m_tuser, (k == v.nbeats - 1) ? v.exp_user : 1'b0);
            k++;
         end
         step(1'b0, '0, 1'b0, '0, 1'b1);
      end
      chk({tag, "_beats"}, k, v.nbeats);
      chk({tag, "_no_extra"}, m_tvalid, 0);
   endtask

   // Random-test model types
   typedef struct { logic [63:0] d; logic l; logic [2:0] u; } in_t;
   typedef struct { logic [15:0] d; logic [15:0] m; logic l; logic u; } out_t;

   in_t         inq[$];
   out_t        expq[$];
   in_t         cur;
   out_t        e;
   logic [7:0]  pb[64];
   logic [63:0] w[3];
   logic [63:0] wd;
   int          plen, nw, beats, first, wi;
   int          acc[3];
   logic        tv, mr, prev_stall, prev_l, prev_u;
   logic [15:0] prev_d;

   initial begin
      vecs[0] = '{64'h0807060504030201, 1'b1, 3'd0, 4, 64'h0807060504030201, '1, 1'b1, 1'b0};
      vecs[1] = '{64'h0807060504030201, 1'b1, 3'd3, 2, 64'h0807060504030201,
                  64'h0000_0000_00FF_FFFF, 1'b1, 1'b1};
      vecs[2] = '{64'h0807060504030201, 1'b1, 3'd1, 1, 64'h0807060504030201,
                  64'h0000_0000_0000_00FF, 1'b1, 1'b1};
      vecs[3] = '{64'h0807060504030201, 1'b0, 3'd5, 4, 64'h0807060504030201, '1, 1'b0, 1'b0};
      vecs[4] = '{64'hA1B2C3D4E5F60718, 1'b1, 3'd4, 2, 64'hA1B2C3D4E5F60718,
                  64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};
      vecs[5] = '{64'h1122334455667788, 1'b1, 3'd7, 4, 64'h1122334455667788,
                  64'h00FF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[6] = '{64'hCAFEBABEDEADBEEF, 1'b1, 3'd2, 1, 64'hCAFEBABEDEADBEEF,
                  64'h0000_0000_0000_FFFF, 1'b1, 1'b0};

      // Reset state
      rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = '0; m_tready = 1'b0;
      step(1'b0, '0, 1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tuser", m_tuser, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_sready", s_tready, 0);
      rst = 1'b0;
      step(1'b0, '0, 1'b0, '0, 1'b0);
      chk("post_rst_tvalid", m_tvalid, 0);
      chk("post_rst_sready", s_tready, 1);

      // Single-word vectors
      for (int i = 0; i < 7; i++) begin
         apply_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Two tiny packets back to back
      step(1'b1, 64'h0000_0000_0000_0011, 1'b1, 3'd1, 1'b1);
      chk("tiny_a_sready", s_tready, 1);
      step(1'b1, 64'h0000_0000_0000_0022, 1'b1, 3'd1, 1'b1);
      chk("tiny_a_tvalid", m_tvalid, 1);
      chk("tiny_a_data", m_tdata[7:0], 8'h11);
      chk("tiny_a_tlast", m_tlast, 1);
      chk("tiny_a_tuser", m_tuser, 1);
      chk("tiny_b_sready", s_tready, 1);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      chk("tiny_b_tvalid", m_tvalid, 1);
      chk("tiny_b_data", m_tdata[7:0], 8'h22);
      chk("tiny_b_tlast", m_tlast, 1);
      chk("tiny_b_tuser", m_tuser, 1);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      chk("tiny_idle", m_tvalid, 0);

      // Streaming three-word packet
      for (int i = 0; i < 3; i++) w[i] = {$urandom, $urandom};
      wi = 0; beats = 0; first = -1;
      for (int c = 0; c < 30 && beats < 12; c++) begin
         wd = (wi < 3) ? w[wi] : '0;
         step(wi < 3, wd, wi == 2, 3'd0, 1'b1);
         if (s_tvalid && s_tready) begin
            acc[wi] = c;
            wi++;
         end
         if (m_tvalid) begin
            if (first < 0) first = c;
            chk("stream_no_bubble", c, first + beats);
            wd = w[beats / 4];
            chk("stream_data", m_tdata, wd[(beats % 4)*16 +: 16]);
            chk("stream_tlast", m_tlast, beats == 11);
            beats++;
         end
      end
      chk("stream_beats", beats, 12);
      chk("stream_accepts", wi, 3);
      chk("stream_gap1", acc[1] - acc[0], 4);
      chk("stream_gap2", acc[2] - acc[1], 4);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      chk("stream_idle", m_tvalid, 0);

      // Reset while the third slice is being offered
      step(1'b1, 64'h0807060504030201, 1'b1, 3'd0, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0, '0, 1'b0);
      chk("midrst_slice2", m_tdata, 16'h0605);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_sready", s_tready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_tvalid", m_tvalid, 0);
      chk("midrst_tdata", m_tdata, 0);
      apply_vec(vecs[5], "post_midrst");

      // Random packets with random backpressure, packet-level reference
      for (int p = 0; p < 1000; p++) begin
         plen = $urandom_range(1, 64);
         for (int i = 0; i < 64; i++) pb[i] = 8'($urandom);
         for (int i = 0; i < plen; i += 2) begin
            e.d = {pb[(i + 1) % 64], pb[i]};
            e.m = (i + 1 < plen) ? 16'hFFFF : 16'h00FF;
            e.l = (i + 2 >= plen);
            e.u = e.l ? 1'(plen % 2) : 1'b0;
            expq.push_back(e);
         end
         nw = (plen + 7) / 8;
         for (int wv = 0; wv < nw; wv++) begin
            for (int j = 0; j < 8; j++) cur.d[j*8 +: 8] = pb[wv*8 + j];
            cur.l = (wv == nw - 1);
            cur.u = cur.l ? 3'(plen % 8) : 3'($urandom);
            inq.push_back(cur);
         end
      end

      tv = 1'b0; prev_stall = 1'b0;
      for (int c = 0; c < 90000 && expq.size() > 0; c++) begin
         if (!tv && inq.size() > 0 && $urandom_range(0, 3) != 0) begin
            tv  = 1'b1;
            cur = inq[0];
         end
         mr = 1'($urandom_range(0, 1));
         step(tv, tv ? cur.d : '0, tv ? cur.l : 1'b0, tv ? cur.u : 3'd0, mr);
         if (prev_stall) begin
            chk("stall_stable", {m_tvalid, m_tlast, m_tuser, m_tdata},
                {1'b1, prev_l, prev_u, prev_d});
         end
         if (m_tvalid && m_tready) begin
            e = expq.pop_front();
            chk("rand_data", m_tdata & e.m, e.d & e.m);
            chk("rand_tlast", m_tlast, e.l);
            chk("rand_tuser", m_tuser, e.u);
         end
         prev_stall = m_tvalid && !m_tready;
         prev_d = m_tdata;
         prev_l = m_tlast;
         prev_u = m_tuser;
         if (tv && s_tready) begin
            void'(inq.pop_front());
            tv = 1'b0;
         end
      end
      chk("rand_drained", expq.size(), 0);
      chk("rand_inputs_used", inq.size(), 0);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      chk("rand_idle", m_tvalid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
